pmem_model: RTL

Behavioural-synthesizable main-memory stage that sits directly downstream of the cache controller and services its miss-fill reads and write-backs over the `mem_*` handshake. It holds a word-addressed 64-bit array. Each accepted read or write completes after a fixed, parameterised latency with a single-cycle completion pulse. It is the `Pmem` endpoint of the shared top-level interface and is used both in simulation and on FPGA.

---
 rtl/pmem_model.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pmem_model.sv
// Word-addressed main-memory model behind the cache controller's mem_* handshake.
// One request at a time; each completes after a fixed latency with a one-cycle valid pulse.
module pmem_model #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned RD_LATENCY = 4,
   parameter int unsigned WR_LATENCY = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_rd_en,
   input  logic              mem_wd_en,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wd_data,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_data_valid,
   output logic              mem_wd_valid
);

   localparam int unsigned IDX_W   = $clog2(DEPTH);
   localparam int unsigned MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
   localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LATENCY - 1);

   typedef enum logic [1:0] {StIdle, StRdWait, StWrWait, StResp} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q;
   logic              rd_valid_q, rd_valid_d;
   logic              wr_valid_q, wr_valid_d;
   logic              rd_fire, wr_fire;

   // Contents start at zero and survive reset; only completed writes change them.
   logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

   // Byte-offset bits and bits above the index alias freely.
   logic unused_addr;
   assign unused_addr = ^{mem_addr[ADDR_W-1:IDX_W+3], mem_addr[2:0]};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      rd_valid_d = 1'b0;
      wr_valid_d = 1'b0;
      rd_fire    = 1'b0;
      wr_fire    = 1'b0;
      case (state_q)
         StIdle: begin
            if (mem_wd_en) begin
               idx_d   = mem_addr[IDX_W+2:3];
               wdata_d = mem_wd_data;
               cnt_d   = WR_LOAD;
               state_d = StWrWait;
            end else if (mem_rd_en) begin
               idx_d   = mem_addr[IDX_W+2:3];
               cnt_d   = RD_LOAD;
               state_d = StRdWait;
            end
         end
         StRdWait: begin
            if (cnt_q == '0) begin
               rd_fire    = 1'b1;
               rd_valid_d = 1'b1;
               state_d    = StResp;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         StWrWait: begin
            if (cnt_q == '0) begin
               wr_fire    = 1'b1;
               wr_valid_d = 1'b1;
               state_d    = StResp;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         idx_q      <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         rd_valid_q <= 1'b0;
         wr_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         wdata_q    <= wdata_d;
         rd_valid_q <= rd_valid_d;
         wr_valid_q <= wr_valid_d;
         if (rd_fire) begin
            rdata_q <= mem_q[idx_q];
         end
      end
   end

   // Reset on the completion edge must still drop the pending write.
   always_ff @(posedge clk) begin
      if (wr_fire && !rst) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   assign mem_data       = rdata_q;
   assign mem_data_valid = rd_valid_q;
   assign mem_wd_valid   = wr_valid_q;

endmodule
